// File: rtl/mdc_pkg.sv
// Shared constants for the 32-point radix-2 MDC FFT pipeline.
// Per-stage delay depths, switch states and counter sizing.
package mdc_pkg;

  localparam int W_DEF    = 9;
  localparam int FFT_N    = 32;
  localparam int DEPTH_S0 = 8;
  localparam int DEPTH_S1 = 4;
  localparam int DEPTH_S2 = 2;
  localparam int DEPTH_S3 = 1;

  typedef enum logic {
    SEL_STRAIGHT = 1'b0,
    SEL_CROSS    = 1'b1
  } sel_e;

  function automatic int cnt_w(int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/mdc_delay_switch_if.sv
// Stream bundle for the MDC delay/switch: two complex input lanes,
// two complex output lanes, valids and the switch state.
interface mdc_delay_switch_if
  import mdc_pkg::*;
#(
  parameter int WIDTH = W_DEF
);

  logic                    in_valid;
  logic signed [WIDTH-1:0] inU_re;
  logic signed [WIDTH-1:0] inU_im;
  logic signed [WIDTH-1:0] inL_re;
  logic signed [WIDTH-1:0] inL_im;
  logic                    out_valid;
  logic signed [WIDTH-1:0] outU_re;
  logic signed [WIDTH-1:0] outU_im;
  logic signed [WIDTH-1:0] outL_re;
  logic signed [WIDTH-1:0] outL_im;
  logic                    sel_dbg;

  modport master (
    output in_valid,
    output inU_re,
    output inU_im,
    output inL_re,
    output inL_im,
    input  out_valid,
    input  outU_re,
    input  outU_im,
    input  outL_re,
    input  outL_im,
    input  sel_dbg
  );

  modport slave (
    input  in_valid,
    input  inU_re,
    input  inU_im,
    input  inL_re,
    input  inL_im,
    output out_valid,
    output outU_re,
    output outU_im,
    output outL_re,
    output outL_im,
    output sel_dbg
  );

endinterface

// File: rtl/mdc_delay_line.sv
// Enable-gated complex shift register; out is the sample
// written DEPTH enabled cycles earlier.
module mdc_delay_line
  import mdc_pkg::*;
#(
  parameter int WIDTH = W_DEF,
  parameter int DEPTH = DEPTH_S1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic signed [WIDTH-1:0] in_re,
  input  logic signed [WIDTH-1:0] in_im,
  output logic signed [WIDTH-1:0] out_re,
  output logic signed [WIDTH-1:0] out_im
);

  logic signed [WIDTH-1:0] re_q [DEPTH];
  logic signed [WIDTH-1:0] im_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        re_q[i] <= '0;
        im_q[i] <= '0;
      end
    end else if (en) begin
      re_q[0] <= in_re;
      im_q[0] <= in_im;
      for (int i = 1; i < DEPTH; i++) begin
        re_q[i] <= re_q[i-1];
        im_q[i] <= im_q[i-1];
      end
    end
  end

  assign out_re = re_q[DEPTH-1];
  assign out_im = im_q[DEPTH-1];

endmodule

// File: rtl/mdc_delay_switch.sv
// MDC delay/switch: lower pre-delay, 2x2 switch, upper post-delay.
// Optional drain input enabled by MDC_DELAY_SWITCH_FLUSH_EN.
module mdc_delay_switch
  import mdc_pkg::*;
#(
  parameter int WIDTH = W_DEF,
  parameter int DEPTH = DEPTH_S1
) (
  input  logic clk,
  input  logic rst_n,
`ifdef MDC_DELAY_SWITCH_FLUSH_EN
  input  logic flush,
`endif
  mdc_delay_switch_if.slave bus
);

  localparam int CW = cnt_w(DEPTH);
  localparam int FW = $clog2(DEPTH + 1);

  logic                    beat;
  logic signed [WIDTH-1:0] u_re, u_im;
  logic signed [WIDTH-1:0] l_re, l_im;
  logic signed [WIDTH-1:0] ld_re, ld_im;
  logic signed [WIDTH-1:0] a_re, a_im;
  logic signed [WIDTH-1:0] b_re, b_im;
  logic signed [WIDTH-1:0] ad_re, ad_im;

  logic [CW-1:0]           cnt_q;
  logic [FW-1:0]           fill_q;
  logic                    fill_done;
  sel_e                    sel;

  logic                    ov_q;
  sel_e                    sel_q;
  logic signed [WIDTH-1:0] ou_re_q, ou_im_q;
  logic signed [WIDTH-1:0] ol_re_q, ol_im_q;

  always_comb begin
    beat = bus.in_valid;
    u_re = bus.inU_re;
    u_im = bus.inU_im;
    l_re = bus.inL_re;
    l_im = bus.inL_im;
`ifdef MDC_DELAY_SWITCH_FLUSH_EN
    // Drain beat: advance with zero samples.
    if (flush && !bus.in_valid) begin
      beat = 1'b1;
      u_re = '0;
      u_im = '0;
      l_re = '0;
      l_im = '0;
    end
`endif
  end

  assign sel       = sel_e'(cnt_q[CW-1]);
  assign fill_done = (fill_q == FW'(DEPTH));

  mdc_delay_line #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_pre (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (beat),
    .in_re  (l_re),
    .in_im  (l_im),
    .out_re (ld_re),
    .out_im (ld_im)
  );

  always_comb begin
    a_re = u_re;
    a_im = u_im;
    b_re = ld_re;
    b_im = ld_im;
    unique case (sel)
      SEL_STRAIGHT: begin
        a_re = u_re;
        a_im = u_im;
        b_re = ld_re;
        b_im = ld_im;
      end
      SEL_CROSS: begin
        a_re = ld_re;
        a_im = ld_im;
        b_re = u_re;
        b_im = u_im;
      end
    endcase
  end

  mdc_delay_line #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_post (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (beat),
    .in_re  (a_re),
    .in_im  (a_im),
    .out_re (ad_re),
    .out_im (ad_im)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      fill_q  <= '0;
      ov_q    <= 1'b0;
      sel_q   <= SEL_STRAIGHT;
      ou_re_q <= '0;
      ou_im_q <= '0;
      ol_re_q <= '0;
      ol_im_q <= '0;
    end else begin
      ov_q <= beat & fill_done;
      if (beat) begin
        cnt_q   <= cnt_q + 1'b1;
        sel_q   <= sel;
        ou_re_q <= ad_re;
        ou_im_q <= ad_im;
        ol_re_q <= b_re;
        ol_im_q <= b_im;
        if (!fill_done)
          fill_q <= fill_q + 1'b1;
      end
    end
  end

  assign bus.out_valid = ov_q;
  assign bus.sel_dbg   = sel_q;
  assign bus.outU_re   = ou_re_q;
  assign bus.outU_im   = ou_im_q;
  assign bus.outL_re   = ol_re_q;
  assign bus.outL_im   = ol_im_q;

endmodule

// File: tb/tb_mdc_delay_switch.sv
// Scoreboard bench for mdc_delay_switch at DEPTH 1, 2 and 4.
// Expected pairs come from a beat-history model of the reorder rule.
module tb_mdc_delay_switch;

  typedef logic signed [8:0] s9_t;
  typedef struct packed {
    s9_t ur;
    s9_t ui;
    s9_t lr;
    s9_t li;
  } smp_t;
  typedef struct packed {
    s9_t  ur;
    s9_t  ui;
    s9_t  lr;
    s9_t  li;
    logic sel;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  s9_t  ur = '0, ui = '0, lr = '0, li = '0;
`ifdef MDC_DELAY_SWITCH_FLUSH_EN
  logic flush = 1'b0;
`endif

  int errors = 0;
  int checks = 0;

  smp_t        hist[$];
  exp_t        q1[$], q2[$], q4[$];
  logic [17:0] cap1[$], cap2[$];

  always #5 clk = ~clk;

  mdc_delay_switch_if #(.WIDTH(9)) b1 ();
  mdc_delay_switch_if #(.WIDTH(9)) b2 ();
  mdc_delay_switch_if #(.WIDTH(9)) b4 ();

  assign b1.in_valid = in_valid;
  assign b1.inU_re = ur;
  assign b1.inU_im = ui;
  assign b1.inL_re = lr;
  assign b1.inL_im = li;
  assign b2.in_valid = in_valid;
  assign b2.inU_re = ur;
  assign b2.inU_im = ui;
  assign b2.inL_re = lr;
  assign b2.inL_im = li;
  assign b4.in_valid = in_valid;
  assign b4.inU_re = ur;
  assign b4.inU_im = ui;
  assign b4.inL_re = lr;
  assign b4.inL_im = li;

  mdc_delay_switch #(.WIDTH(9), .DEPTH(1)) u_d1 (
    .clk   (clk),
    .rst_n (rst_n),
`ifdef MDC_DELAY_SWITCH_FLUSH_EN
    .flush (flush),
`endif
    .bus   (b1)
  );

  mdc_delay_switch #(.WIDTH(9), .DEPTH(2)) u_d2 (
    .clk   (clk),
    .rst_n (rst_n),
`ifdef MDC_DELAY_SWITCH_FLUSH_EN
    .flush (flush),
`endif
    .bus   (b2)
  );

  mdc_delay_switch #(.WIDTH(9), .DEPTH(4)) u_d4 (
    .clk   (clk),
    .rst_n (rst_n),
`ifdef MDC_DELAY_SWITCH_FLUSH_EN
    .flush (flush),
`endif
    .bus   (b4)
  );

  // Model: beat k is in the cross state when (k / d) is odd.
  function automatic smp_t lane_a(int d, int k);
    smp_t r, s, p;
    r = '0;
    s = hist[k];
    p = (k >= d) ? hist[k-d] : '0;
    if (((k / d) % 2) == 0) begin
      r.ur = s.ur;
      r.ui = s.ui;
    end else begin
      r.ur = p.lr;
      r.ui = p.li;
    end
    return r;
  endfunction

  function automatic smp_t lane_b(int d, int k);
    smp_t r, s, p;
    r = '0;
    s = hist[k];
    p = (k >= d) ? hist[k-d] : '0;
    if (((k / d) % 2) == 0) begin
      r.ur = p.lr;
      r.ui = p.li;
    end else begin
      r.ur = s.ur;
      r.ui = s.ui;
    end
    return r;
  endfunction

  function automatic exp_t model(int d, int n);
    exp_t e;
    smp_t a, b;
    a = lane_a(d, n - d);
    b = lane_b(d, n);
    e.ur  = a.ur;
    e.ui  = a.ui;
    e.lr  = b.ur;
    e.li  = b.ui;
    e.sel = ((n / d) % 2) == 1;
    return e;
  endfunction

  task automatic push_exp();
    int n;
    n = hist.size() - 1;
    if (n >= 1) q1.push_back(model(1, n));
    if (n >= 2) q2.push_back(model(2, n));
    if (n >= 4) q4.push_back(model(4, n));
  endtask

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic mon(input int d, input exp_t act);
    exp_t e;
    bit   got;
    got = 0;
    e   = '0;
    case (d)
      1: if (q1.size() > 0) begin e = q1.pop_front(); got = 1; end
      2: if (q2.size() > 0) begin e = q2.pop_front(); got = 1; end
      default:
        if (q4.size() > 0) begin e = q4.pop_front(); got = 1; end
    endcase
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL unexpected_valid d=%0d actual=%0h required=none",
               d, act);
    end else if (act !== e) begin
      errors++;
      $display("FAIL pair d=%0d actual=%0h required=%0h", d, act, e);
    end
    if (d == 1) cap1.push_back({act.ur, act.lr});
    if (d == 2) cap2.push_back({act.ur, act.lr});
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (b1.out_valid)
        mon(1, {b1.outU_re, b1.outU_im, b1.outL_re, b1.outL_im, b1.sel_dbg});
      if (b2.out_valid)
        mon(2, {b2.outU_re, b2.outU_im, b2.outL_re, b2.outL_im, b2.sel_dbg});
      if (b4.out_valid)
        mon(4, {b4.outU_re, b4.outU_im, b4.outL_re, b4.outL_im, b4.sel_dbg});
    end
  end

  function automatic s9_t rnd();
    case ($urandom % 4)
      0:       return s9_t'(-256);
      1:       return s9_t'(255);
      default: return s9_t'($urandom);
    endcase
  endfunction

  task automatic beat(input s9_t a, input s9_t b,
                      input s9_t c, input s9_t e);
    smp_t s;
    s.ur = a;
    s.ui = b;
    s.lr = c;
    s.li = e;
    hist.push_back(s);
    push_exp();
    ur = a;
    ui = b;
    lr = c;
    li = e;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      ur = rnd();
      ui = rnd();
      lr = rnd();
      li = rnd();
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    hist.delete();
    q1.delete();
    q2.delete();
    q4.delete();
    cap1.delete();
    cap2.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic t1_beats(input int gap);
    for (int i = 0; i < 8; i++) begin
      beat(s9_t'(10 + i), s9_t'(-i), s9_t'(20 + i), s9_t'(i + 3));
      if (gap > 0) idle(gap);
    end
    idle(2);
  endtask

  task automatic t1_check(input string nm);
    int eu[6] = '{10, 11, 20, 21, 14, 15};
    int el[6] = '{12, 13, 22, 23, 16, 17};
    chk({nm, "_count"}, cap2.size(), 6);
    for (int i = 0; i < 6; i++)
      chk(nm, (i < cap2.size()) ? cap2[i] : 18'h3ffff,
          {s9_t'(eu[i]), s9_t'(el[i])});
  endtask

  initial begin
    logic [15:0] pat;
    int          du[3];
    int          dl[3];
    pat = 16'b0000111100001111;
    du  = '{1, 5, 3};
    dl  = '{2, 6, 4};

    #3;
    chk("rst_out_valid", b4.out_valid, 0);
    chk("rst_outU_re", b4.outU_re, 0);
    chk("rst_outL_im", b4.outL_im, 0);
    chk("rst_sel_dbg", b4.sel_dbg, 0);
    do_reset();

    // continuous DEPTH=2 sequence
    t1_beats(0);
    t1_check("t1_pair");

    // same stream with 3-cycle gaps
    do_reset();
    t1_beats(3);
    t1_check("t2_pair");

    // asynchronous reset mid-frame
    do_reset();
    for (int i = 0; i < 6; i++) beat(rnd(), rnd(), rnd(), rnd());
    #2;
    rst_n = 1'b0;
    hist.delete();
    q1.delete();
    q2.delete();
    q4.delete();
    #1;
    chk("mid_rst_valid1", b1.out_valid, 0);
    chk("mid_rst_valid4", b4.out_valid, 0);
    chk("mid_rst_outU4", b4.outU_re, 0);
    chk("mid_rst_outL2", b2.outL_re, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    beat(rnd(), rnd(), rnd(), rnd());
    chk("refill_valid1", b1.out_valid, 0);
    chk("refill_valid2", b2.out_valid, 0);
    beat(rnd(), rnd(), rnd(), rnd());
    chk("refill_valid2b", b2.out_valid, 0);
    chk("refill_valid4", b4.out_valid, 0);
    idle(2);

    // extremes at DEPTH=4 with sel_dbg pattern
    do_reset();
    for (int i = 0; i < 16; i++) begin
      beat(($urandom % 2) ? s9_t'(-256) : s9_t'(255),
           ($urandom % 2) ? s9_t'(-256) : s9_t'(255),
           ($urandom % 2) ? s9_t'(-256) : s9_t'(255),
           ($urandom % 2) ? s9_t'(-256) : s9_t'(255));
      chk("sel_dbg", b4.sel_dbg, pat[15-i]);
    end
    idle(2);

    // per-beat switching at DEPTH=1
    do_reset();
    for (int i = 0; i < 4; i++)
      beat(s9_t'(1 + i), s9_t'(0), s9_t'(5 + i), s9_t'(0));
    idle(2);
    chk("d1_count", cap1.size(), 3);
    for (int i = 0; i < 3; i++)
      chk("d1_pair", (i < cap1.size()) ? cap1[i] : 18'h3ffff,
          {s9_t'(du[i]), s9_t'(dl[i])});

    // randomized bursty traffic
    do_reset();
    for (int i = 0; i < 300; i++) begin
      beat(rnd(), rnd(), rnd(), rnd());
      if ($urandom % 3 == 0) idle($urandom_range(1, 4));
    end
    idle(3);

`ifdef MDC_DELAY_SWITCH_FLUSH_EN
    do_reset();
    for (int i = 0; i < 8; i++) begin
      beat(rnd(), rnd(), rnd(), rnd());
      if ($urandom % 2 == 0) idle(1);
    end
    for (int i = 0; i < 4; i++) begin
      hist.push_back('0);
      push_exp();
      ur = rnd();
      ui = rnd();
      lr = rnd();
      li = rnd();
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
    end
    idle(3);
`endif

    chk("q1_drained", q1.size(), 0);
    chk("q2_drained", q2.size(), 0);
    chk("q4_drained", q4.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
